// File: rtl/adder_pkg.sv
// Shared types and default sizing for the add/sub pipeline.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int ADD_W_DEF   = 9;
    localparam int ADD_LAT_DEF = 2;
    localparam int OVF_CNT_W   = 16;

endpackage

// File: rtl/add_sub_pipe_stage.sv
// One valid/ready register slice; payload only loads with a valid beat.
// Latency 1 cycle; ready is combinational from dn_ready so a full slice still streams.
module add_sub_pipe_stage
    import adder_pkg::*;
#(
    parameter int DW = ADD_W_DEF + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    // Empty, or the current beat leaves this cycle: either way we can refill.
    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined unsigned add/subtract with carry/borrow flag; overflow counter under ADD_SUB_PIPE_OVF_CNT_EN.
// Latency LAT cycles; full backpressure, in_ready is combinational from out_ready through the stage chain.
module add_sub_pipe
    import adder_pkg::*;
#(
    parameter int W   = ADD_W_DEF,
    parameter int LAT = ADD_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_op,
    input  logic [W-1:0]         in_a,
    input  logic [W-1:0]         in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W:0]           out_data,
    output logic                 out_ovf,
    input  logic                 ovf_clr,
    output logic [OVF_CNT_W-1:0] ovf_cnt
);

    op_e        op;
    logic [W:0] sum;
    logic [W:0] diff;
    logic [W:0] res;

    assign op   = op_e'(in_op);
    assign sum  = {1'b0, in_a} + {1'b0, in_b};
    assign diff = {1'b0, in_a} - {1'b0, in_b};
    // Bit W is the carry for add and the borrow for subtract.
    assign res  = (op == OP_SUB) ? diff : sum;

    logic           vld [LAT+1];
    logic           rdy [LAT+1];
    logic [W+1:0]   dat [LAT+1];

    assign vld[0]   = in_valid;
    assign dat[0]   = {res[W], res};
    assign rdy[LAT] = out_ready;
    assign in_ready = rdy[0];

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        add_sub_pipe_stage #(
            .DW(W + 2)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (vld[k]),
            .up_ready (rdy[k]),
            .up_data  (dat[k]),
            .dn_valid (vld[k+1]),
            .dn_ready (rdy[k+1]),
            .dn_data  (dat[k+1])
        );
    end

    assign out_valid = vld[LAT];
    assign out_data  = dat[LAT][W:0];
    assign out_ovf   = dat[LAT][W+1];

`ifdef ADD_SUB_PIPE_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ovf_clr) begin
            cnt <= '0;
        end else if (out_valid && out_ready && out_ovf && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign ovf_cnt = cnt;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign ovf_cnt        = '0;
`endif

endmodule
